// File: rtl/snake_snd_pkg.sv
// Shared sound definitions for the Snake sequencer and the downstream tone stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snake_snd_pkg;

    // Tone code carried from the jingle ROM to the note output decoder
    typedef enum logic [1:0] {
        TONE_REST = 2'd0,
        TONE_DO   = 2'd1,
        TONE_SO   = 2'd2
    } tone_t;

    // Sequence ids; the numeric order is also the preemption priority
    typedef enum logic [1:0] {
        SEQ_NONE  = 2'd0,
        SEQ_EAT   = 2'd1,
        SEQ_START = 2'd2,
        SEQ_DIE   = 2'd3
    } seq_t;

    // Default tone dividers at 50 MHz: DO = 262 Hz, SO = 392 Hz
    localparam logic [17:0] DO_DIV_DEF = 18'd190839;
    localparam logic [17:0] SO_DIV_DEF = 18'd127550;

endpackage

// File: rtl/snake_sfx_rom.sv
// Jingle ROM: (sequence id, note index) -> (tone, duration in ticks, last-note flag).
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
module snake_sfx_rom
    import snake_snd_pkg::*;
(
    input  seq_t        i_seq,
    input  logic [1:0]  i_idx,
    output tone_t       o_tone,
    output logic [3:0]  o_dur,
    output logic        o_last
);

    // Fixed jingle table; unused slots read as a one-tick rest marked last
    always_comb begin
        o_tone = TONE_REST;
        o_dur  = 4'd1;
        o_last = 1'b1;
        case (i_seq)
            SEQ_EAT: begin
                case (i_idx)
                    2'd0:    begin o_tone = TONE_DO; o_dur = 4'd2; o_last = 1'b0; end
                    2'd1:    begin o_tone = TONE_SO; o_dur = 4'd2; o_last = 1'b1; end
                    default: begin o_tone = TONE_REST; o_dur = 4'd1; o_last = 1'b1; end
                endcase
            end
            SEQ_START: begin
                case (i_idx)
                    2'd0:    begin o_tone = TONE_DO; o_dur = 4'd1; o_last = 1'b0; end
                    2'd1:    begin o_tone = TONE_SO; o_dur = 4'd1; o_last = 1'b0; end
                    2'd2:    begin o_tone = TONE_DO; o_dur = 4'd1; o_last = 1'b0; end
                    default: begin o_tone = TONE_SO; o_dur = 4'd3; o_last = 1'b1; end
                endcase
            end
            SEQ_DIE: begin
                case (i_idx)
                    2'd0:    begin o_tone = TONE_SO;   o_dur = 4'd2; o_last = 1'b0; end
                    2'd1:    begin o_tone = TONE_DO;   o_dur = 4'd2; o_last = 1'b0; end
                    2'd2:    begin o_tone = TONE_REST; o_dur = 4'd1; o_last = 1'b0; end
                    default: begin o_tone = TONE_DO;   o_dur = 4'd6; o_last = 1'b1; end
                endcase
            end
            default: begin
                o_tone = TONE_REST;
                o_dur  = 4'd1;
                o_last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/snake_sfx_sequencer.sv
// Turns single-cycle game events into timed DO/SO note jingles for the tone stage.
// Latency: busy one cycle after the event, first note two cycles after the event.
// Backpressure: none; lower/equal priority events while busy are dropped, higher ones preempt.
module snake_sfx_sequencer
    import snake_snd_pkg::*;
#(
    parameter logic [21:0] TICK_CYCLES = 22'd2500000,
    parameter logic [21:0] GAP_CYCLES  = 22'd250000,
    parameter logic [17:0] DO_DIV      = DO_DIV_DEF,
    parameter logic [17:0] SO_DIV      = SO_DIV_DEF
)(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        evt_eat,
    input  logic        evt_start,
    input  logic        evt_die,
    output logic        enb1,
    output logic        enb2,
    output logic [17:0] freq_datas,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    seq_t        r_seq;
    logic [1:0]  r_idx;
    logic [21:0] r_cnt;
    logic [3:0]  r_tick;
    logic        r_enb1;
    logic        r_enb2;
    logic [17:0] r_freq;

    seq_t        w_evt_seq;
    logic        w_accept;
    tone_t       w_tone;
    logic [3:0]  w_dur;
    logic [3:0]  w_dur_eff;
    logic        w_last;
    logic        w_tick_end;
    logic        w_note_end;
    logic        w_gap_end;

    // r_idx always points at the note being played, or the one after the current gap
    snake_sfx_rom u_rom (
        .i_seq  (r_seq),
        .i_idx  (r_idx),
        .o_tone (w_tone),
        .o_dur  (w_dur),
        .o_last (w_last)
    );

    assign w_evt_seq  = evt_die   ? SEQ_DIE   :
                        evt_start ? SEQ_START :
                        evt_eat   ? SEQ_EAT   : SEQ_NONE;
    // DONE behaves like IDLE for new events; otherwise only strictly higher priority preempts
    assign w_accept   = (w_evt_seq != SEQ_NONE) &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE) || (w_evt_seq > r_seq));
    assign w_dur_eff  = (w_dur == 4'd0) ? 4'd1 : w_dur;
    // Compare count+1 against the target so a zero-length setting degrades to one cycle
    assign w_tick_end = ({1'b0, r_cnt} + 23'd1) >= {1'b0, TICK_CYCLES};
    assign w_gap_end  = ({1'b0, r_cnt} + 23'd1) >= {1'b0, GAP_CYCLES};
    assign w_note_end = w_tick_end && (r_tick == (w_dur_eff - 4'd1));

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an accepted event overrides whatever the sequence was doing
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = ST_IDLE;
            ST_LOAD: w_next = ST_PLAY;
            ST_PLAY: if (w_note_end) w_next = w_last ? ST_DONE : ST_GAP;
            ST_GAP:  if (w_gap_end)  w_next = ST_PLAY;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (w_accept) begin
            w_next = ST_LOAD;
        end
    end

    // Sequence id, note index, and the cycle/tick counters that time each note and gap
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_seq  <= SEQ_NONE;
            r_idx  <= 2'd0;
            r_cnt  <= 22'd0;
            r_tick <= 4'd0;
        end else begin
            if (w_accept) begin
                r_seq <= w_evt_seq;
            end
            if (w_next == ST_LOAD) begin
                r_idx  <= 2'd0;
                r_cnt  <= 22'd0;
                r_tick <= 4'd0;
            end else if ((r_state == ST_PLAY) && (w_next != ST_PLAY)) begin
                r_idx  <= r_idx + 2'd1;
                r_cnt  <= 22'd0;
                r_tick <= 4'd0;
            end else if ((r_state == ST_GAP) && (w_next == ST_PLAY)) begin
                r_cnt  <= 22'd0;
                r_tick <= 4'd0;
            end else if (r_state == ST_PLAY) begin
                if (w_tick_end) begin
                    r_cnt  <= 22'd0;
                    r_tick <= r_tick + 4'd1;
                end else if (r_cnt != 22'h3FFFFF) begin
                    r_cnt  <= r_cnt + 22'd1;
                end
            end else if ((r_state == ST_GAP) && (r_cnt != 22'h3FFFFF)) begin
                r_cnt <= r_cnt + 22'd1;
            end
        end
    end

    // Registered note outputs: loaded for PLAY, held across LOAD so a preempted note
    // stays audible until the new jingle starts, silent everywhere else
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_enb1 <= 1'b0;
            r_enb2 <= 1'b0;
            r_freq <= 18'd0;
        end else if (w_next == ST_PLAY) begin
            r_enb1 <= (w_tone == TONE_DO);
            r_enb2 <= (w_tone == TONE_SO);
            r_freq <= (w_tone == TONE_DO) ? DO_DIV :
                      (w_tone == TONE_SO) ? SO_DIV : 18'd0;
        end else if (w_next != ST_LOAD) begin
            r_enb1 <= 1'b0;
            r_enb2 <= 1'b0;
            r_freq <= 18'd0;
        end
    end

    assign enb1       = r_enb1;
    assign enb2       = r_enb2;
    assign freq_datas = r_freq;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);

endmodule
